video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Raster timing source for the colour-bar pattern stage. Runs on the 12 MHz board clock
//  and generates the pixel rate internally as a clock-enable (no derived clock).
//  Emits hsync/vsync, display_on and hpos/vpos, plus line/frame strobes.
//  The pattern stage decodes hpos bits into rgb; the LED blinker counts frame_start.
// PARAMETERS
//  CLK_DIV          2    clk cycles per pixel (>=1); 12 MHz / 2 = 6 MHz pixel rate
//  H_DISPLAY        256  visible pixels per line
//  H_FRONT          40   horizontal front porch, pixels
//  H_SYNC           25   horizontal sync width, pixels
//  H_BACK           60   horizontal back porch, pixels (total 381 px = 63.5 us)
//  V_DISPLAY        240  visible lines per frame
//  V_FRONT          5    vertical front porch, lines
//  V_SYNC           3    vertical sync width, lines
//  V_BACK           14   vertical back porch, lines (total 262 lines, ~60.1 Hz)
//  H_SYNC_POLARITY  1    1 = hsync active-low, 0 = active-high
//  V_SYNC_POLARITY  1    1 = vsync active-low, 0 = active-high
// PORTS
//  clk          in   1  board clock, 12 MHz
//  reset_n      in   1  asynchronous active-low reset
//  pix_ce       out  1  pixel clock-enable, one clk wide, once every CLK_DIV clks
//  hsync        out  1  horizontal sync, level per H_SYNC_POLARITY
//  vsync        out  1  vertical sync, level per V_SYNC_POLARITY
//  display_on   out  1  1 while hpos < H_DISPLAY and vpos < V_DISPLAY
//  hpos         out  9  pixel column, 0 .. H_TOTAL-1
//  vpos         out  9  line number, 0 .. V_TOTAL-1
//  line_start   out  1  one-clk pulse when hpos wraps to 0
//  frame_start  out  1  one-clk pulse when (hpos,vpos) wraps to (0,0)
// BEHAVIOUR
//  - Reset (async assert, sync release): div_cnt=0, hpos=0, vpos=0, pix_ce=0, display_on=1,
//    hsync/vsync at inactive level, line_start=frame_start=0.
//  - Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_ce=1 in the clk cycle where
//    div_cnt==CLK_DIV-1, so the first pix_ce is CLK_DIV clks after reset release.
//    CLK_DIV=1 gives pix_ce constantly 1.
//  - Counters advance only on the clk edge that samples pix_ce=1.
//  - hpos: increments, wrapping H_TOTAL-1 -> 0, where H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK.
//  - vpos: increments only on the hpos wrap, wrapping V_TOTAL-1 -> 0 (simultaneous wrap
//    of both counters is the frame boundary).
//  - Line order: display, front porch, sync, back porch.
//    hsync is active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1].
//    vsync is active for vpos in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1].
//  - Output timing: hsync, vsync, display_on, line_start and frame_start are registered.
//    They are decoded from the next-state counter values, so they change on the same edge
//    as hpos/vpos. Zero skew: every output always describes the current hpos/vpos.
//  - line_start = 1 for exactly one clk after the edge where hpos became 0 (including
//    the frame wrap); 0 otherwise and during reset.
//  - frame_start = 1 for exactly one clk after the edge where hpos and vpos both became 0.
//    A frame_start cycle is always also a line_start cycle.
//  - Widths: H_TOTAL and V_TOTAL must each be <= 512. Out-of-range values are a parameter
//    error; the design stops elaboration via a generate-time check.
//  - Reset mid-line or mid-frame: all state returns to reset values immediately
//    (asynchronous). The next frame is timed from (0,0) after release; no partial-state carry.
//  - No combinational path from reset_n to any output except through flops.
// TESTING
//  - Reset: hold reset_n=0 for 5 clks at an arbitrary point -> hpos=vpos=0, display_on=1,
//    hsync=vsync=1, strobes 0. After release, first pix_ce on clk 2.
//  - Line timing (defaults): hsync low for exactly 25 pix_ce (50 clks), starting at hpos=296.
//    line_start period = 762 clks. display_on falls at hpos=256.
//  - Frame timing: frame_start period = 262*381*2 = 199644 clks. vsync low for lines
//    245..247 = 2286 clks. display_on=0 for all of vpos 240..261.
//  - Wrap boundary: at hpos=380, vpos=261 the next pix_ce edge gives hpos=0, vpos=0,
//    line_start=1 and frame_start=1 in the same clk. Both return to 0 on the next clk.
//  - Polarity/divider: H_SYNC_POLARITY=0, V_SYNC_POLARITY=0, CLK_DIV=1 -> syncs active-high,
//    pix_ce stuck at 1, frame_start period 99822 clks.
//  - Async reset mid-frame: drop reset_n at vpos=100, hpos=150, between clk edges ->
//    outputs hold reset values within the same half-cycle, with no glitch on release.

Source files
------------

// File: rtl/video_timing_if.sv
// Raster timing bundle shared between the timing generator and its consumers
// (pattern stage, LED blinker).
interface video_timing_if;
   logic       pix_ce;
   logic       hsync;
   logic       vsync;
   logic       display_on;
   logic [8:0] hpos;
   logic [8:0] vpos;
   logic       line_start;
   logic       frame_start;

   modport master (
      output pix_ce, hsync, vsync, display_on, hpos, vpos, line_start, frame_start
   );

   modport slave (
      input pix_ce, hsync, vsync, display_on, hpos, vpos, line_start, frame_start
   );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing source: divides the board clock into a pixel clock-enable and
// produces sync, blanking, position counters and line/frame strobes.
module video_timing_gen #(
   parameter int CLK_DIV         = 2,
   parameter int H_DISPLAY       = 256,
   parameter int H_FRONT         = 40,
   parameter int H_SYNC          = 25,
   parameter int H_BACK          = 60,
   parameter int V_DISPLAY       = 240,
   parameter int V_FRONT         = 5,
   parameter int V_SYNC          = 3,
   parameter int V_BACK          = 14,
   parameter int H_SYNC_POLARITY = 1,
   parameter int V_SYNC_POLARITY = 1
) (
   input  logic           clk,
   input  logic           reset_n,
   video_timing_if.master vid
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   // Counters are 9 bits wide, so larger rasters cannot be represented.
   generate
      if ((H_TOTAL > 512) || (V_TOTAL > 512) || (CLK_DIV < 1) || (H_SYNC < 1) || (V_SYNC < 1)) begin : g_param_error
         $error("video_timing_gen: raster totals must be <= 512, CLK_DIV and sync widths >= 1");
      end
   endgenerate

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
   localparam logic [8:0] H_DISP     = 9'(H_DISPLAY);
   localparam logic [8:0] V_DISP     = 9'(V_DISPLAY);
   localparam logic [8:0] HS_FIRST   = 9'(H_DISPLAY + H_FRONT);
   localparam logic [8:0] HS_LAST    = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [8:0] VS_FIRST   = 9'(V_DISPLAY + V_FRONT);
   localparam logic [8:0] VS_LAST    = 9'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic       H_IDLE     = (H_SYNC_POLARITY != 0) ? 1'b1 : 1'b0;
   localparam logic       V_IDLE     = (V_SYNC_POLARITY != 0) ? 1'b1 : 1'b0;

   logic [DIV_W-1:0] div_cnt_r;
   logic             pix_ce_r;
   logic [8:0]       hpos_r;
   logic [8:0]       vpos_r;
   logic             hsync_r;
   logic             vsync_r;
   logic             display_on_r;
   logic             line_start_r;
   logic             frame_start_r;

   logic             div_last_s;
   logic             h_wrap_s;
   logic             v_wrap_s;
   logic [8:0]       hpos_next_s;
   logic [8:0]       vpos_next_s;
   logic             h_act_s;
   logic             v_act_s;

   // Next-state counter values; all registered outputs are decoded from these
   // so they switch on the same edge as hpos/vpos.
   always_comb begin
      div_last_s  = (div_cnt_r == DIV_LAST);
      h_wrap_s    = pix_ce_r && (hpos_r == H_LAST);
      v_wrap_s    = h_wrap_s && (vpos_r == V_LAST);
      hpos_next_s = hpos_r;
      vpos_next_s = vpos_r;
      if (pix_ce_r) begin
         if (hpos_r == H_LAST) begin
            hpos_next_s = 9'd0;
         end else begin
            hpos_next_s = hpos_r + 9'd1;
         end
      end else begin
         hpos_next_s = hpos_r;
      end
      if (h_wrap_s) begin
         if (vpos_r == V_LAST) begin
            vpos_next_s = 9'd0;
         end else begin
            vpos_next_s = vpos_r + 9'd1;
         end
      end else begin
         vpos_next_s = vpos_r;
      end
      h_act_s = (hpos_next_s >= HS_FIRST) && (hpos_next_s <= HS_LAST);
      v_act_s = (vpos_next_s >= VS_FIRST) && (vpos_next_s <= VS_LAST);
   end

   // Pixel divider: pix_ce is registered from the terminal count, so it lands
   // CLK_DIV clocks after reset release and is constantly high for CLK_DIV=1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_r <= '0;
         pix_ce_r  <= 1'b0;
      end else begin
         if (div_last_s) begin
            div_cnt_r <= '0;
         end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
         end
         pix_ce_r <= div_last_s;
      end
   end

   // Raster counters and decoded outputs, all advancing together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hpos_r        <= 9'd0;
         vpos_r        <= 9'd0;
         hsync_r       <= H_IDLE;
         vsync_r       <= V_IDLE;
         display_on_r  <= 1'b1;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         hpos_r        <= hpos_next_s;
         vpos_r        <= vpos_next_s;
         hsync_r       <= h_act_s ^ H_IDLE;
         vsync_r       <= v_act_s ^ V_IDLE;
         display_on_r  <= (hpos_next_s < H_DISP) && (vpos_next_s < V_DISP);
         line_start_r  <= h_wrap_s;
         frame_start_r <= v_wrap_s;
      end
   end

   assign vid.pix_ce      = pix_ce_r;
   assign vid.hsync       = hsync_r;
   assign vid.vsync       = vsync_r;
   assign vid.display_on  = display_on_r;
   assign vid.hpos        = hpos_r;
   assign vid.vpos        = vpos_r;
   assign vid.line_start  = line_start_r;
   assign vid.frame_start = frame_start_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default raster, a small raster, and a small
// active-high raster with CLK_DIV=1, each checked against an arithmetic model.
`timescale 1ns/1ps
module tb_video_timing_gen;

   typedef logic [23:0] vec_t;

   localparam vec_t RST_POL1 = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 9'd0};
   localparam vec_t RST_POL0 = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 9'd0};

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   na = 0;
   int   nb = 0;
   int   nc = 0;
   vec_t qa[$];
   vec_t qb[$];
   vec_t qc[$];

   video_timing_if vif_a ();
   video_timing_if vif_b ();
   video_timing_if vif_c ();

   video_timing_gen dut_a (.clk(clk), .reset_n(reset_n), .vid(vif_a));

   video_timing_gen #(
      .CLK_DIV(3), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(3), .H_BACK(5),
      .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) dut_b (.clk(clk), .reset_n(reset_n), .vid(vif_b));

   video_timing_gen #(
      .CLK_DIV(1), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(3), .H_BACK(5),
      .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .H_SYNC_POLARITY(0), .V_SYNC_POLARITY(0)
   ) dut_c (.clk(clk), .reset_n(reset_n), .vid(vif_c));

   always #5 clk = ~clk;

   // Expected outputs after n clock edges since reset release, derived from
   // pixel arithmetic rather than from counters.
   function automatic vec_t model(int n, int d, int hd, int hf, int hs, int ht,
                                  int vd, int vf, int vs, int vt, bit pol);
      int p, h, v;
      bit ce, pe, ha, va;
      p  = (n >= 1) ? (n - 1) / d : 0;
      h  = p % ht;
      v  = (p / ht) % vt;
      ce = (n >= 1) && ((n % d) == 0);
      pe = (n >= 2) && (((n - 1) % d) == 0);
      ha = (h >= hd + hf) && (h < hd + hf + hs);
      va = (v >= vd + vf) && (v < vd + vf + vs);
      return {ce, pol ? !ha : ha, pol ? !va : va, (h < hd) && (v < vd),
              pe && (h == 0), pe && (h == 0) && (v == 0), 9'(h), 9'(v)};
   endfunction

   function automatic vec_t obs_a();
      return {vif_a.pix_ce, vif_a.hsync, vif_a.vsync, vif_a.display_on,
              vif_a.line_start, vif_a.frame_start, vif_a.hpos, vif_a.vpos};
   endfunction
   function automatic vec_t obs_b();
      return {vif_b.pix_ce, vif_b.hsync, vif_b.vsync, vif_b.display_on,
              vif_b.line_start, vif_b.frame_start, vif_b.hpos, vif_b.vpos};
   endfunction
   function automatic vec_t obs_c();
      return {vif_c.pix_ce, vif_c.hsync, vif_c.vsync, vif_c.display_on,
              vif_c.line_start, vif_c.frame_start, vif_c.hpos, vif_c.vpos};
   endfunction

   // Scoreboard producer: push the expected state for every edge and reset.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         na <= 0; nb <= 0; nc <= 0;
         qa.push_back(model(0, 2, 256, 40, 25, 381, 240, 5, 3, 262, 1'b1));
         qb.push_back(model(0, 3, 16, 4, 3, 28, 10, 2, 2, 17, 1'b1));
         qc.push_back(model(0, 1, 16, 4, 3, 28, 10, 2, 2, 17, 1'b0));
      end else begin
         na <= na + 1; nb <= nb + 1; nc <= nc + 1;
         qa.push_back(model(na + 1, 2, 256, 40, 25, 381, 240, 5, 3, 262, 1'b1));
         qb.push_back(model(nb + 1, 3, 16, 4, 3, 28, 10, 2, 2, 17, 1'b1));
         qc.push_back(model(nc + 1, 1, 16, 4, 3, 28, 10, 2, 2, 17, 1'b0));
      end
   end

   task automatic test_reset();
      int first_a, first_b, first_c;
      reset_n = 1'b0;
      repeat (5) @(negedge clk);
      vectors += 3;
      if (obs_a() !== RST_POL1) begin miscompares++; $display("FAIL reset_a: got %h expected %h", obs_a(), RST_POL1); end
      if (obs_b() !== RST_POL1) begin miscompares++; $display("FAIL reset_b: got %h expected %h", obs_b(), RST_POL1); end
      if (obs_c() !== RST_POL0) begin miscompares++; $display("FAIL reset_c: got %h expected %h", obs_c(), RST_POL0); end
      reset_n = 1'b1;
      first_a = -1; first_b = -1; first_c = -1;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         #1;
         if (first_a < 0 && vif_a.pix_ce === 1'b1) first_a = i;
         if (first_b < 0 && vif_b.pix_ce === 1'b1) first_b = i;
         if (first_c < 0 && vif_c.pix_ce === 1'b1) first_c = i;
      end
      vectors += 3;
      if (first_a != 2) begin miscompares++; $display("FAIL first_pix_ce_a: got clk %0d expected 2", first_a); end
      if (first_b != 3) begin miscompares++; $display("FAIL first_pix_ce_b: got clk %0d expected 3", first_b); end
      if (first_c != 1) begin miscompares++; $display("FAIL first_pix_ce_c: got clk %0d expected 1", first_c); end
   endtask

   task automatic test_line_timing();
      vec_t exp;
      int   hs_start, ls_last, n_hs, n_ls, n_de;
      logic hs_prev, de_prev;
      hs_start = -1; ls_last = -1; n_hs = 0; n_ls = 0; n_de = 0;
      hs_prev = vif_a.hsync; de_prev = vif_a.display_on;
      for (int c = 0; c < 2400; c++) begin
         @(negedge clk);
         exp = qa[$]; qa.delete(); vectors++;
         if (obs_a() !== exp) begin miscompares++; $display("FAIL line_sb: got %h expected %h", obs_a(), exp); end
         if (hs_prev === 1'b1 && vif_a.hsync === 1'b0) begin
            hs_start = c; vectors++;
            if (vif_a.hpos !== 9'd296) begin miscompares++; $display("FAIL hsync_start: got hpos %0d expected 296", vif_a.hpos); end
         end
         if (hs_prev === 1'b0 && vif_a.hsync === 1'b1 && hs_start >= 0) begin
            n_hs++; vectors++;
            if (c - hs_start != 50) begin miscompares++; $display("FAIL hsync_width: got %0d clks expected 50", c - hs_start); end
         end
         if (vif_a.line_start === 1'b1) begin
            if (ls_last >= 0) begin
               n_ls++; vectors++;
               if (c - ls_last != 762) begin miscompares++; $display("FAIL line_period: got %0d clks expected 762", c - ls_last); end
            end
            ls_last = c;
         end
         if (de_prev === 1'b1 && vif_a.display_on === 1'b0) begin
            n_de++; vectors++;
            if (vif_a.hpos !== 9'd256) begin miscompares++; $display("FAIL display_fall: got hpos %0d expected 256", vif_a.hpos); end
         end
         hs_prev = vif_a.hsync; de_prev = vif_a.display_on;
      end
      vectors++;
      if (n_hs == 0 || n_ls == 0 || n_de == 0) begin
         miscompares++; $display("FAIL line_events: got hs=%0d ls=%0d de=%0d expected all >0", n_hs, n_ls, n_de);
      end
   endtask

   task automatic test_frame_timing();
      vec_t exp;
      int   fs_last, vs_start, n_fs, n_vs;
      logic vs_prev;
      fs_last = -1; vs_start = -1; n_fs = 0; n_vs = 0;
      vs_prev = vif_b.vsync;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         exp = qb[$]; qb.delete(); vectors++;
         if (obs_b() !== exp) begin miscompares++; $display("FAIL frame_sb: got %h expected %h", obs_b(), exp); end
         if (vif_b.vpos >= 9'd10) begin
            vectors++;
            if (vif_b.display_on !== 1'b0) begin miscompares++; $display("FAIL vblank_display: got %b expected 0 at vpos %0d", vif_b.display_on, vif_b.vpos); end
         end
         if (vif_b.frame_start === 1'b1) begin
            vectors++;
            if (vif_b.line_start !== 1'b1) begin miscompares++; $display("FAIL fs_implies_ls: got ls %b expected 1", vif_b.line_start); end
            if (fs_last >= 0) begin
               n_fs++; vectors++;
               if (c - fs_last != 1428) begin miscompares++; $display("FAIL frame_period: got %0d clks expected 1428", c - fs_last); end
            end
            fs_last = c;
         end
         if (vs_prev === 1'b1 && vif_b.vsync === 1'b0) begin
            vs_start = c; vectors++;
            if (vif_b.vpos !== 9'd12 || vif_b.hpos !== 9'd0) begin miscompares++; $display("FAIL vsync_start: got (%0d,%0d) expected (0,12)", vif_b.hpos, vif_b.vpos); end
         end
         if (vs_prev === 1'b0 && vif_b.vsync === 1'b1 && vs_start >= 0) begin
            n_vs++; vectors++;
            if (c - vs_start != 168) begin miscompares++; $display("FAIL vsync_width: got %0d clks expected 168", c - vs_start); end
         end
         vs_prev = vif_b.vsync;
      end
      vectors++;
      if (n_fs == 0 || n_vs == 0) begin miscompares++; $display("FAIL frame_events: got fs=%0d vs=%0d expected both >0", n_fs, n_vs); end
   endtask

   task automatic test_wrap();
      bit found;
      found = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
         @(negedge clk);
         if (vif_b.hpos === 9'd27 && vif_b.vpos === 9'd16) found = 1'b1;
      end
      if (found) begin
         for (int c = 0; c < 10 && vif_b.hpos === 9'd27; c++) @(negedge clk);
      end
      vectors++;
      if (!found || vif_b.hpos !== 9'd0 || vif_b.vpos !== 9'd0 || vif_b.line_start !== 1'b1 || vif_b.frame_start !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap_edge: got found=%0d pos=(%0d,%0d) ls=%b fs=%b expected (0,0) ls=1 fs=1",
                  found, vif_b.hpos, vif_b.vpos, vif_b.line_start, vif_b.frame_start);
      end
      @(negedge clk);
      vectors++;
      if (vif_b.line_start !== 1'b0 || vif_b.frame_start !== 1'b0 || vif_b.hpos !== 9'd0) begin
         miscompares++;
         $display("FAIL wrap_after: got ls=%b fs=%b hpos=%0d expected ls=0 fs=0 hpos=0", vif_b.line_start, vif_b.frame_start, vif_b.hpos);
      end
   endtask

   task automatic test_polarity();
      vec_t exp;
      int   fs_last, n_fs;
      logic hs_exp, vs_exp;
      fs_last = -1; n_fs = 0;
      for (int c = 0; c < 1200; c++) begin
         @(negedge clk);
         exp = qc[$]; qc.delete(); vectors++;
         if (obs_c() !== exp) begin miscompares++; $display("FAIL pol_sb: got %h expected %h", obs_c(), exp); end
         hs_exp = (vif_c.hpos >= 9'd20) && (vif_c.hpos <= 9'd22);
         vs_exp = (vif_c.vpos >= 9'd12) && (vif_c.vpos <= 9'd13);
         vectors++;
         if (vif_c.pix_ce !== 1'b1 || vif_c.hsync !== hs_exp || vif_c.vsync !== vs_exp) begin
            miscompares++;
            $display("FAIL pol_sync: got ce=%b hs=%b vs=%b expected ce=1 hs=%b vs=%b", vif_c.pix_ce, vif_c.hsync, vif_c.vsync, hs_exp, vs_exp);
         end
         if (vif_c.frame_start === 1'b1) begin
            if (fs_last >= 0) begin
               n_fs++; vectors++;
               if (c - fs_last != 476) begin miscompares++; $display("FAIL pol_frame_period: got %0d clks expected 476", c - fs_last); end
            end
            fs_last = c;
         end
      end
      vectors++;
      if (n_fs == 0) begin miscompares++; $display("FAIL pol_frame_events: got 0 periods expected >0"); end
   endtask

   task automatic test_async_reset();
      vec_t exp;
      bit   found;
      int   fs_b, fs_c;
      found = 1'b0;
      for (int c = 0; c < 2000 && !found; c++) begin
         @(negedge clk);
         if (vif_b.vpos === 9'd5 && vif_b.hpos === 9'd10) found = 1'b1;
      end
      vectors++;
      if (!found) begin miscompares++; $display("FAIL async_position: got timeout expected (10,5)"); end
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      vectors += 3;
      if (obs_a() !== RST_POL1) begin miscompares++; $display("FAIL async_a: got %h expected %h", obs_a(), RST_POL1); end
      if (obs_b() !== RST_POL1) begin miscompares++; $display("FAIL async_b: got %h expected %h", obs_b(), RST_POL1); end
      if (obs_c() !== RST_POL0) begin miscompares++; $display("FAIL async_c: got %h expected %h", obs_c(), RST_POL0); end
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      #1;
      vectors++;
      if (obs_b() !== RST_POL1) begin miscompares++; $display("FAIL release_b: got %h expected %h", obs_b(), RST_POL1); end
      fs_b = -1; fs_c = -1;
      qb.delete(); qc.delete();
      for (int k = 1; k <= 1500; k++) begin
         @(negedge clk);
         exp = qb[$]; qb.delete(); vectors++;
         if (obs_b() !== exp) begin miscompares++; $display("FAIL restart_sb_b: got %h expected %h", obs_b(), exp); end
         exp = qc[$]; qc.delete(); vectors++;
         if (obs_c() !== exp) begin miscompares++; $display("FAIL restart_sb_c: got %h expected %h", obs_c(), exp); end
         if (fs_b < 0 && vif_b.frame_start === 1'b1) fs_b = k;
         if (fs_c < 0 && vif_c.frame_start === 1'b1) fs_c = k;
      end
      vectors += 2;
      if (fs_b != 1429) begin miscompares++; $display("FAIL restart_fs_b: got clk %0d expected 1429", fs_b); end
      if (fs_c != 477) begin miscompares++; $display("FAIL restart_fs_c: got clk %0d expected 477", fs_c); end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_wrap();
      test_polarity();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
